// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: request/ack handshake with
// word-aligned address, lane enables and lane-positioned data.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store per start, byte-lane alignment and
// load extension. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mem_write,
    input  logic [3:0]         be,
    input  logic [2:0]         funct3,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [31:0]        wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               misalign,
    output logic [31:0]        rdata,
    load_store_unit_if.master  mem
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t             state, next;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [3:0]         be_q;
    logic [31:0]        wd_q;
    logic [CNT_W-1:0]   cnt;
    logic               err_q;
    logic [31:0]        rdata_q;

    logic               accept;
    logic               ack_ok;
    logic               tmo;
    logic               trap;
    logic               req;
    logic [3:0]         be_sh;
    logic [31:0]        rd_sh;
    logic [31:0]        rd_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap = ((be == 4'b0011) && (addr[1:0] == 2'd3)) ||
                  ((be == 4'b1111) && (addr[1:0] != 2'd0));
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next   = state;
        accept = 1'b0;
        ack_ok = 1'b0;
        tmo    = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        req    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    busy   = 1'b1;
                    accept = 1'b1;
                    next   = trap ? DONE : REQ;
                end
            end
            REQ: begin
                busy = 1'b1;
                req  = 1'b1;
                if (mem.mem_ack) begin
                    ack_ok = 1'b1;
                    next   = DONE;
                end else if (WD_EN && (cnt == CNT_LAST)) begin
                    tmo  = 1'b1;
                    next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Enables shifted past lane 3 fall off the 4-bit result.
    assign be_sh = be << addr[1:0];

    assign rd_sh = mem.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'b100:  rd_ext = {24'd0, rd_sh[7:0]};
            3'b001:  rd_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b101:  rd_ext = {16'd0, rd_sh[15:0]};
            default: rd_ext = rd_sh;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q   <= mem_write;
                f3_q   <= funct3;
                off_q  <= addr[1:0];
                addr_q <= {addr[ADDR_W-1:2], 2'b00};
                be_q   <= be_sh;
                wd_q   <= wdata << {addr[1:0], 3'b000};
                cnt    <= '0;
                err_q  <= trap;
            end
            if (req) cnt <= cnt + CNT_W'(1);
            if (tmo) err_q <= 1'b1;
            if (ack_ok && !we_q) rdata_q <= rd_ext;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         mis_q <= 1'b0;
        else if (accept) mis_q <= trap;
    end
    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

    assign err   = err_q;
    assign rdata = rdata_q;

    // Bus qualifiers are forced low outside REQ so an idle bus never shows stale lanes.
    assign mem.mem_req   = req;
    assign mem.mem_we    = req & we_q;
    assign mem.mem_be    = req ? be_q : '0;
    assign mem.mem_wdata = req ? wd_q : '0;
    assign mem.mem_addr  = addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a behavioural
// model of lane placement, load extension, latency and watchdog timeout.
module tb_load_store_unit;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mem_write;
    logic [3:0]  be;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err, misalign;
    logic [31:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rdata_model = '0;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_write (mem_write),
        .be        (be),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .misalign  (misalign),
        .rdata     (rdata),
        .mem       (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] w,
                                               input logic [1:0] off);
        longint v;
        v = longint'(w) / (longint'(1) << (8 * off));
        case (f3)
            3'b000: begin v = v % 256;   if (v > 127)   v = v - 256;   end
            3'b100: v = v % 256;
            3'b001: begin v = v % 65536; if (v > 32767) v = v - 65536; end
            3'b101: v = v % 65536;
            default: ;
        endcase
        return 32'(v);
    endfunction

    function automatic bit is_trap(input logic [3:0] b, input logic [1:0] off);
`ifdef LSU_MISALIGN_TRAP_EN
        return (b == 4'b0011 && off == 2'd3) || (b == 4'b1111 && off != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    // dly = number of REQ cycles before the one carrying ack; dly >= TMO means no ack
    task automatic run_op(input logic mw, input logic [3:0] b, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int dly,
                          input logic [31:0] rw);
        logic [1:0]  off;
        logic [7:0]  be_wide;
        logic [31:0] exp_wd;
        bit          trap, got_done, acked;
        int          cyc, reqc, exp_cyc;
        off     = a[1:0];
        trap    = is_trap(b, off);
        be_wide = {4'b0000, b} << off;
        exp_wd  = wd * (32'd1 << (8 * off));
        acked   = !trap && (dly < int'(TMO));
        exp_cyc = trap ? 1 : (acked ? dly + 2 : int'(TMO) + 1);

        @(negedge clk);
        start = 1'b1; mem_write = mw; be = b; funct3 = f3; addr = a; wdata = wd;
        #1 check("busy_c0", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0; mem_write = $urandom; addr = $urandom; wdata = $urandom;
        cyc = 1; reqc = 0; got_done = 0;
        while (cyc < 20 && !got_done) begin
            if (done) begin
                got_done = 1;
            end else begin
                reqc++;
                check("mem_req", {31'd0, bus.mem_req}, 32'd1);
                if (reqc == 1) begin
                    check("mem_addr",  bus.mem_addr, a & 32'hFFFF_FFFC);
                    check("mem_be",    {28'd0, bus.mem_be}, {28'd0, be_wide[3:0]});
                    check("mem_wdata", bus.mem_wdata, exp_wd);
                    check("mem_we",    {31'd0, bus.mem_we}, {31'd0, mw});
                    check("busy_req",  {31'd0, busy}, 32'd1);
                end
                bus.mem_rdata = $urandom;
                if (reqc == dly + 1) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rw;
                end
                @(negedge clk);
                bus.mem_ack = 1'b0;
                cyc++;
            end
        end
        check("done_seen", {31'd0, got_done}, 32'd1);
        if (acked && !mw) rdata_model = load_model(f3, rw, off);
        check("done_cycle", cyc, exp_cyc);
        check("req_cycles", reqc, exp_cyc - 1);
        check("err",      {31'd0, err}, {31'd0, !acked});
        check("misalign", {31'd0, misalign}, {31'd0, trap});
        check("busy_done", {31'd0, busy}, 32'd0);
        check("req_done", {31'd0, bus.mem_req}, 32'd0);
        check("be_idle",  {28'd0, bus.mem_be}, 32'd0);
        check("rdata",    rdata, rdata_model);
    endtask

    task automatic reset_mid_req();
        @(negedge clk);
        start = 1'b1; mem_write = 1'b0; be = 4'b1111; funct3 = 3'b010; addr = 32'h4000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("req_before_rst", {31'd0, bus.mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1 check("req_in_rst",  {31'd0, bus.mem_req}, 32'd0);
        check("busy_in_rst", {31'd0, busy}, 32'd0);
        check("rdata_in_rst", rdata, 32'd0);
        rdata_model = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_after_rst", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [2:0] f3s [8];
        logic [3:0] bes [8];
        logic [2:0] f3;
        logic [3:0] b;
        int k;
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010};
        bes = '{4'b0001, 4'b0011, 4'b1111, 4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b1111};

        rst = 1'b1; start = 1'b0; mem_write = 1'b0; be = '0; funct3 = '0;
        addr = '0; wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        #1;
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_req",   {31'd0, bus.mem_req}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op(1'b1, 4'b0001, 3'b000, 32'h1003, 32'h0000_00A5, 1, 32'h0);
        run_op(1'b0, 4'b0001, 3'b000, 32'h2002, 32'h0, 0, 32'h12F0_3456);
        check("lb_value", rdata, 32'hFFFF_FFF0);
        run_op(1'b0, 4'b0001, 3'b100, 32'h2002, 32'h0, 0, 32'h12F0_3456);
        check("lbu_value", rdata, 32'h0000_00F0);
        run_op(1'b0, 4'b0011, 3'b001, 32'h2002, 32'h0, 0, 32'h8001_1234);
        check("lh_value", rdata, 32'hFFFF_8001);
        run_op(1'b0, 4'b0011, 3'b101, 32'h2002, 32'h0, 0, 32'h8001_1234);
        check("lhu_value", rdata, 32'h0000_8001);
        run_op(1'b0, 4'b1111, 3'b010, 32'h2000, 32'h0, 0, 32'h8001_1234);
        check("lw_value", rdata, 32'h8001_1234);
        run_op(1'b0, 4'b1111, 3'b010, 32'h5000, 32'h0, 99, 32'h0);
        check("tmo_keeps_rdata", rdata, 32'h8001_1234);
        run_op(1'b0, 4'b1111, 3'b010, 32'h5004, 32'h0, int'(TMO) - 1, 32'hCAFE_F00D);
        reset_mid_req();
        run_op(1'b0, 4'b1111, 3'b010, 32'h6000, 32'h0, 1, 32'h1357_9BDF);
        run_op(1'b0, 4'b1111, 3'b010, 32'h3001, 32'h0, 0, 32'hA1B2_C3D4);
        run_op(1'b1, 4'b0011, 3'b001, 32'h3003, 32'h0000_BEEF, 0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 7);
            f3 = f3s[k];
            b  = bes[k];
            run_op(k >= 5, b, f3, $urandom, $urandom,
                   ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 3), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
